// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the single-bit seq link: transmitter state encoding and the
// default pattern that both the transmitter and the detector are built around.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } tx_state_e;

    localparam logic [3:0] SeqDefaultPat = 4'b1011;

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in serial-out shift register, MSB first. Shifting fills with zeros so the
// serial output drops to 0 once the loaded word has been fully shifted out.
module seq_piso_shreg #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [PAT_W-1:0] din,
    output logic             dout
);

    logic [PAT_W-1:0] shr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shr_q <= '0;
        end else if (ld) begin
            shr_q <= din;
        end else if (sh) begin
            shr_q <= {shr_q[PAT_W-2:0], 1'b0};
        end
    end

    assign dout = shr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a stored pattern out MSB first with a valid
// qualifier, optionally repeating it with an idle gap between repeats.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = SeqDefaultPat,
    parameter int unsigned      GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             start,
    input  logic             rpt,
    output logic             seq,
    output logic             seq_vld,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = $clog2(PAT_W);
    // GAP=0 never enters StGap, but the counter still needs a legal width.
    localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e        state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             seq_vld_q, busy_q, done_q, done_d;
    logic             sh_ld, sh_sh;
    logic [PAT_W-1:0] sh_din;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        sh_ld     = 1'b0;
        sh_sh     = 1'b0;
        sh_din    = pat_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    pat_d = pat_in;
                end
                if (start) begin
                    state_d   = StShift;
                    sh_ld     = 1'b1;
                    sh_din    = load ? pat_in : pat_q;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            end
            StShift: begin
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (rpt && (GAP > 0)) begin
                        state_d = StGap;
                        sh_sh   = 1'b1;
                    end else if (rpt) begin
                        sh_ld = 1'b1;
                    end else begin
                        state_d = StIdle;
                        sh_sh   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    sh_sh     = 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d   = StShift;
                    sh_ld     = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pat_q     <= PAT_RST;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            seq_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            seq_vld_q <= (state_d == StShift);
            busy_q    <= (state_d != StIdle);
            done_q    <= done_d;
        end
    end

    // The shift register MSB is the seq flop; it is all-zero outside StShift.
    seq_piso_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .ld   (sh_ld),
        .sh   (sh_sh),
        .din  (sh_din),
        .dout (seq)
    );

    assign seq_vld = seq_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
